// File: rtl/mips_multicycle_if.sv
// Shared instruction/data memory port of the multicycle MIPS core.
`timescale 1ns/1ps

// Handshake: the core raises mem_req with mem_we/mem_addr/mem_wdata and
// holds all of them unchanged until the memory answers with mem_ack=1.
// The transfer completes in the cycle where mem_req=1 and mem_ack=1. On a
// read, mem_rdata is valid in that same cycle. mem_ack may come in the
// cycle mem_req rises. mem_ack seen while mem_req=0 has no effect.
interface mips_multicycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core with one shared req/ack memory port and a bus-error timeout.
// Optional MIPS_MC_PERF_CNT_EN adds the cycle_cnt / instret_cnt counter ports.
`timescale 1ns/1ps

module mips_multicycle #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  mips_multicycle_if.master  mem,
  output logic [31:0]        pc,
  output logic               retire,
  output logic               halted,
  output logic               bus_err,
  output logic [2:0]         state_dbg
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  localparam logic [15:0] WAIT_LIM = 16'(WAIT_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] ir, a, b, t, alu_out, mdr, alu_res;
  logic [15:0] wait_cnt;
  logic [31:0] rf [0:31];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z, rf_rs, rf_rt, jtgt;
  logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_ctl, legal, br_taken;
  logic req, ack, timeout;
  logic rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_z = {16'h0000, imm};
  assign jtgt  = {pc[31:28], ir[25:0], 2'b00};
  assign rf_rs = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rf_rt = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign is_r     = (op == OP_R);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_ctl   = is_beq || is_bne || is_j || is_jal || is_jr;
  assign br_taken = (is_beq && (a == b)) || (is_bne && (a != b));

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      case (funct)
        FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
        FN_SLT, FN_SLTU: legal = (ir[10:6] == 5'd0);
        default:         legal = 1'b0;
      endcase
    end else begin
      case (op)
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  // ADD/ADDI never trap; LW/SW share the sign-extended add for the address.
  always_comb begin
    alu_res = 32'd0;
    if (is_r) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_res = a + b;
        FN_SUB, FN_SUBU: alu_res = a - b;
        FN_AND:          alu_res = a & b;
        FN_OR:           alu_res = a | b;
        FN_XOR:          alu_res = a ^ b;
        FN_NOR:          alu_res = ~(a | b);
        FN_SLT:          alu_res = {31'd0, ($signed(a) < $signed(b))};
        FN_SLTU:         alu_res = {31'd0, (a < b)};
        default:         alu_res = 32'd0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_res = a + imm_s;
        OP_SLTI:  alu_res = {31'd0, ($signed(a) < $signed(imm_s))};
        OP_SLTIU: alu_res = {31'd0, (a < imm_s)};
        OP_ANDI:  alu_res = a & imm_z;
        OP_ORI:   alu_res = a | imm_z;
        OP_XORI:  alu_res = a ^ imm_z;
        OP_LUI:   alu_res = {imm, 16'h0000};
        default:  alu_res = 32'd0;
      endcase
    end
  end

  // Reset gates the request combinationally so an in-flight access drops at once.
  assign req            = ((state == S_FETCH) || (state == S_MEM)) && !reset;
  assign ack            = req && mem.mem_ack;
  assign timeout        = (WAIT_TIMEOUT != 0) && req && !mem.mem_ack && (wait_cnt == WAIT_LIM);
  assign mem.mem_req    = req;
  assign mem.mem_we     = req && (state == S_MEM) && is_sw;
  assign mem.mem_addr   = req ? ((state == S_FETCH) ? pc : alu_out) : 32'd0;
  assign mem.mem_wdata  = mem.mem_we ? b : 32'd0;
  assign halted         = (state == S_HALT);
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        if (ack)          state_nx = S_DECODE;
        else if (timeout) state_nx = S_HALT;
      end
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw || is_sw) state_nx = S_MEM;
        else if (is_ctl) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else state_nx = S_WB;
      end
      S_MEM: begin
        if (ack) begin
          if (is_lw) state_nx = S_WB;
          else begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (timeout) state_nx = S_HALT;
      end
      S_WB: begin
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 32'd0;
      a        <= 32'd0;
      b        <= 32'd0;
      t        <= 32'd0;
      alu_out  <= 32'd0;
      mdr      <= 32'd0;
      wait_cnt <= 16'd0;
      bus_err  <= 1'b0;
    end else begin
      // Counter restarts whenever a transfer completes or no request is open.
      if (!req || ack) wait_cnt <= 16'd0;
      else             wait_cnt <= wait_cnt + 16'd1;
      if (timeout) bus_err <= 1'b1;
      case (state)
        S_FETCH: if (ack) begin
          ir <= mem.mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a <= rf_rs;
          b <= rf_rt;
          t <= pc + {imm_s[29:0], 2'b00};
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (br_taken)              pc <= t;
          else if (is_j || is_jal)   pc <= jtgt;
          else if (is_jr)            pc <= a;
        end
        S_MEM: if (ack && is_lw) mdr <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  // JAL links in EXEC, before pc takes the jump target.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = is_r ? rd : rt;
    rf_wd = is_lw ? mdr : alu_out;
    if ((state == S_EXEC) && is_jal) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = pc;
    end else if (state == S_WB) begin
      rf_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= rf_wd;
  end

`ifdef MIPS_MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
